// File: rtl/led_pkg.sv
// Shared definitions for the 4-LED pattern sequencer.
//   LED_W    : width of the LED bank
//   mode_e   : display mode encoding (FLOW_L=0, FLOW_R=1, BLINK=2, PINGPONG=3)
//   dir_e    : pingpong travel direction
//   SEED_*   : pattern loaded when a mode is entered
//   seed_of  : seed lookup by mode
//   is_onehot: legality test for rotating/pingpong patterns
package led_pkg;

  localparam int unsigned LED_W = 4;

  typedef enum logic [1:0] {
    FLOW_L   = 2'd0,
    FLOW_R   = 2'd1,
    BLINK    = 2'd2,
    PINGPONG = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] SEED_FLOW_L   = 4'b0001;
  localparam logic [LED_W-1:0] SEED_FLOW_R   = 4'b1000;
  localparam logic [LED_W-1:0] SEED_BLINK    = 4'b0000;
  localparam logic [LED_W-1:0] SEED_PINGPONG = 4'b0001;

  function automatic logic [LED_W-1:0] seed_of(input mode_e m);
    logic [LED_W-1:0] s;
    case (m)
      FLOW_L:   s = SEED_FLOW_L;
      FLOW_R:   s = SEED_FLOW_R;
      BLINK:    s = SEED_BLINK;
      default:  s = SEED_PINGPONG;
    endcase
    return s;
  endfunction

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - LED_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// accepted-level register. Emits a one-cycle press pulse on the accepted
// released->pressed (1->0) transition; release produces no pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_n        : raw active-low button, asynchronous to clk
//   press        : registered one-cycle pulse per accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive disagreeing samples; the level flips on
  // the DEBOUNCE_CYC-th one, and any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer: step-tick divider plus a mode/pattern state
// machine (FLOW_L, FLOW_R, BLINK, PINGPONG). A debounced button press
// advances the mode; pause freezes the step counter and the LEDs.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key_n              : raw active-low mode button
//   pause              : 1 holds the step counter and LEDs
//   led                : LED drive, 1 = on
//   mode               : current display mode
//   tick               : one-cycle pulse when led shows a new step
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_n,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int unsigned    TW      = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  CNT_MAX = TW'(TICK_DIV - 1);

  logic             press;
  logic             step;
  logic [TW-1:0]    count_q, count_d;
  logic [LED_W-1:0] led_q, led_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic             tick_q, tick_d;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .key_n (key_n),
    .press (press)
  );

  assign step = (count_q == CNT_MAX) && !pause;

  // Press restarts the step period and overrides a coincident step.
  always_comb begin
    count_d = count_q;
    if (press)
      count_d = '0;
    else if (!pause)
      count_d = (count_q == CNT_MAX) ? '0 : count_q + TW'(1);
  end

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      led_d  = seed_of(mode_d);
      dir_d  = DIR_UP;
    end else if (step) begin
      tick_d = 1'b1;
      case (mode_q)
        FLOW_L:
          led_d = is_onehot(led_q) ? {led_q[LED_W-2:0], led_q[LED_W-1]} : SEED_FLOW_L;
        FLOW_R:
          led_d = is_onehot(led_q) ? {led_q[0], led_q[LED_W-1:1]} : SEED_FLOW_R;
        BLINK:
          // Anything other than all-off goes to all-off, so a corrupted
          // pattern rejoins the 0000/1111 cycle in one step.
          led_d = (led_q == '0) ? '1 : '0;
        default: begin
          // Bounce at either end even if the stored direction disagrees
          // with the position, so the pattern never shifts out of range.
          if (!is_onehot(led_q)) begin
            led_d = SEED_PINGPONG;
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            if (led_q[LED_W-1]) begin
              led_d = led_q >> 1;
              dir_d = DIR_DOWN;
            end else begin
              led_d = led_q << 1;
              dir_d = led_d[LED_W-1] ? DIR_DOWN : DIR_UP;
            end
          end else begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              dir_d = DIR_UP;
            end else begin
              led_d = led_q >> 1;
              dir_d = led_d[0] ? DIR_UP : DIR_DOWN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q <= '0;
      led_q   <= SEED_FLOW_L;
      mode_q  <= FLOW_L;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_DIV=4, DEBOUNCE_CYC=3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_led_pattern_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_n;
  logic       pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       tick;

  int vectors;
  int miscompares;

  led_pattern_ctrl #(
    .TICK_DIV     (4),
    .DEBOUNCE_CYC (3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_n),
    .pause     (pause),
    .led       (led),
    .mode      (mode),
    .tick      (tick)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Clean press: mode changes at the 6th edge after key_n falls
  // (2 sync + 3 debounce + 1 register); then release is debounced.
  task automatic press_key(input int old_mode, input int new_mode, input int seed);
    key_n = 1'b0;
    cyc(5);
    chk("press_pre_mode", int'(mode), old_mode);
    cyc(1);
    chk("press_mode", int'(mode), new_mode);
    chk("press_seed", int'(led), seed);
    chk("press_tick", int'(tick), 0);
    key_n = 1'b1;
    cyc(5);
  endtask

  int flow_exp[4] = '{'b0010, 'b0100, 'b1000, 'b0001};
  int pp_exp[7]   = '{'b0100, 'b1000, 'b0100, 'b0010, 'b0001, 'b0010, 'b0100};

  initial begin
    vectors     = 0;
    miscompares = 0;
    key_n       = 1'b1;
    pause       = 1'b0;
    sys_rst_n   = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_led", int'(led), 'b0001);
    chk("rst_mode", int'(mode), 0);
    chk("rst_tick", int'(tick), 0);
    cyc(2);
    sys_rst_n = 1'b1;

    // FLOW_L: steps at edges 4, 8, 12, 16 after release
    chk("flowl_init", int'(led), 'b0001);
    for (int e = 1; e <= 17; e++) begin
      cyc(1);
      chk("flowl_led", int'(led), (e < 4) ? 'b0001 : flow_exp[(e / 4) - 1]);
      chk("flowl_tick", int'(tick), (e % 4 == 0 && e <= 16) ? 1 : 0);
    end

    // Clean press held 10 cycles (count=1 at start, step lands at edge 3)
    key_n = 1'b0;
    cyc(3);
    chk("cp_step_led", int'(led), 'b0010);
    chk("cp_step_tick", int'(tick), 1);
    cyc(2);
    chk("cp_pre_mode", int'(mode), 0);
    cyc(1);
    chk("cp_mode", int'(mode), 1);
    chk("cp_seed", int'(led), 'b1000);
    chk("cp_tick", int'(tick), 0);
    cyc(3);
    chk("cp_hold_led", int'(led), 'b1000);
    chk("cp_hold_tick", int'(tick), 0);
    cyc(1);
    chk("cp_next_led", int'(led), 'b0100);
    chk("cp_next_tick", int'(tick), 1);
    key_n = 1'b1;
    cyc(7);
    chk("rel_mode", int'(mode), 1);
    chk("rel_led", int'(led), 'b0010);

    // Glitch: 2 low cycles must not be accepted
    key_n = 1'b0;
    cyc(2);
    key_n = 1'b1;
    cyc(2);
    chk("gl_mode_a", int'(mode), 1);
    chk("gl_led_a", int'(led), 'b0001);
    cyc(2);
    chk("gl_mode_b", int'(mode), 1);
    chk("gl_led_b", int'(led), 'b1000);

    // BLINK
    press_key(1, 2, 'b0000);
    chk("bl_led0", int'(led), 'b1111);
    cyc(3);
    chk("bl_led1", int'(led), 'b0000);
    chk("bl_tick1", int'(tick), 1);
    cyc(4);
    chk("bl_led2", int'(led), 'b1111);
    chk("bl_tick2", int'(tick), 1);

    // PINGPONG: 0010 already shown, then the remaining 7 steps
    press_key(2, 3, 'b0001);
    chk("pp_led0", int'(led), 'b0010);
    for (int i = 0; i < 7; i++) begin
      cyc((i == 0) ? 3 : 4);
      chk("pp_led", int'(led), pp_exp[i]);
      chk("pp_tick", int'(tick), 1);
    end

    // Wrap back to FLOW_L
    press_key(3, 0, 'b0001);
    chk("wrap_led", int'(led), 'b0010);

    // Pause at count 3 for 5 cycles
    cyc(2);
    pause = 1'b1;
    cyc(1);
    chk("pz_led_a", int'(led), 'b0010);
    chk("pz_tick_a", int'(tick), 0);
    cyc(4);
    chk("pz_led_b", int'(led), 'b0010);
    chk("pz_tick_b", int'(tick), 0);
    pause = 1'b0;
    cyc(1);
    chk("pz_resume_led", int'(led), 'b0100);
    chk("pz_resume_tick", int'(tick), 1);

    // Press timed to land on a step edge: seed wins, tick stays low
    cyc(2);
    press_key(0, 1, 'b1000);
    chk("col_after_led", int'(led), 'b0100);

    // Into PINGPONG down-phase, then async reset between edges
    press_key(1, 2, 'b0000);
    press_key(2, 3, 'b0001);
    cyc(11);
    chk("ar_pre_led", int'(led), 'b0100);
    chk("ar_pre_tick", int'(tick), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_led", int'(led), 'b0001);
    chk("ar_mode", int'(mode), 0);
    chk("ar_tick", int'(tick), 0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    cyc(3);
    chk("ar_e3_led", int'(led), 'b0001);
    chk("ar_e3_tick", int'(tick), 0);
    cyc(1);
    chk("ar_e4_led", int'(led), 'b0010);
    chk("ar_e4_tick", int'(tick), 1);
    chk("ar_e4_mode", int'(mode), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 4-LED bank on the board. It owns the step-tick divider and a pattern state machine with four display modes. A debounced push-button cycles through the modes, and a pause input freezes the display. It sits between the board button/LED pins and replaces free-running single-pattern LED logic.

## Interface
- `TICK_DIV`, default 10_000_000: sys_clk cycles per pattern step (0.2 s at 50 MHz); must be ≥2.
- `DEBOUNCE_CYC`, default 1_000_000: consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz); must be ≥2.
- `sys_clk` in 1: system clock; the only clock.
- `sys_rst_n` in 1: asynchronous reset, active-low.
- `key_n` in 1: raw push-button, active-low, asynchronous to sys_clk.
- `pause` in 1: level, synchronous; 1 freezes the step counter and the LEDs.
- `led` out 4: LED drive; 1 = on.
- `mode` out 2: current mode (0 FLOW_L, 1 FLOW_R, 2 BLINK, 3 PINGPONG).
- `tick` out 1: one-cycle pulse, high in the cycle `led` shows a newly stepped value.

## Operation
- **Reset state** (immediate, no clock needed): `led`=0001, `mode`=FLOW_L, `tick`=0, step counter=0, debounced key=1 (released), pingpong direction=up.
- **Step counter**
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `step` = (count==TICK_DIV-1) && !pause.
  - While `pause`=1, count holds.
- **Key path**
  - Two-flop synchronizer, then a stability counter.
  - The accepted level changes only after the synced input differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any agreeing sample clears the stability counter.
  - A `press` event is the accepted 1→0 transition, one cycle wide. Release produces no event.
- **Press handling**
  - `mode` ← mode+1 (3 wraps to 0).
  - `led` ← seed of the new mode; step counter ← 0; direction ← up.
  - Press takes effect even while `pause`=1.
  - Press has priority over a simultaneous `step`; no step is taken that cycle and `tick` stays 0.
- **Step handling** (per mode, applied on `step`):
  - FLOW_L: seed 0001; rotate left, 0001→0010→0100→1000→0001.
  - FLOW_R: seed 1000; rotate right, 1000→0100→0010→0001→1000.
  - BLINK: seed 0000; invert, 0000↔1111.
  - PINGPONG: seed 0001, direction up.
    - Up: shift left; on reaching 1000, direction flips to down.
    - Down: shift right; on reaching 0001, direction flips to up.
    - Sequence: 0001,0010,0100,1000,0100,0010,0001,0010…
- **Outside step/press:** `led` and `mode` hold.
- **Illegal `led` value** (e.g. an SEU): the next step or press restores a legal pattern. FLOW/PINGPONG steps from a non-one-hot value reload the seed.

## Timing
- All outputs are registered.
- Step latency: `led` and `tick` update on the same rising edge at which count wraps TICK_DIV-1→0. Step period is exactly TICK_DIV cycles with no pause.
- After reset release, the first step is at the TICK_DIV-th rising edge.
- Key latency: a clean press changes `mode`/`led` 2 (sync) + DEBOUNCE_CYC + 1 cycles after `key_n` falls, to within one cycle for synchronizer phase.
- Pause: asserting `pause` in the cycle where count==TICK_DIV-1 suppresses that step. Deasserting it resumes from the held count, with no extra or lost counts.
- Reset mid-operation: all state returns to reset values asynchronously; the debounce counter also clears.

## Structure
- Shared package `led_pkg`:
  - Mode encoding constants (FLOW_L=0, FLOW_R=1, BLINK=2, PINGPONG=3).
  - Seed constants per mode.
  - LED width constant (4).
- Counter widths are $clog2 of the parameters.
- Sub-module `key_debounce` (synchronizer, stability counter, accepted level, `press` pulse), parameterised by DEBOUNCE_CYC.
- Top contains the step counter and the mode/pattern FSM.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_CYC=3.
- **Reset and FLOW_L:** release reset, run 17 cycles → `led`=0001 initially; 0010, 0100, 1000, 0001 at edges 4, 8, 12, 16; `tick` high exactly at those edges.
- **Clean press:** hold `key_n`=0 for 10 cycles → `mode` 0→1 once, `led`=1000, step counter restarts; next step 4 cycles later gives 0100. Release produces no change.
- **Glitch rejection:** pulse `key_n` low for 2 cycles → `mode` and `led` unchanged.
- **PINGPONG and BLINK:** 3 presses → `mode`=3; 8 steps give 0010,0100,1000,0100,0010,0001,0010,0100. Next press → `mode`=0, `led`=0001. BLINK mode alternates 0000/1111.
- **Pause and collision:**
  - Assert `pause` at count 3 for 5 cycles → no step; the step occurs exactly 1 cycle after deassert.
  - Force `press` coincident with `step` → seed loaded, `tick`=0.
- **Async reset mid-run:** drop `sys_rst_n` between clock edges during PINGPONG down-phase → `led`=0001, `mode`=0, `tick`=0 immediately. After release, the first step is at edge 4.
